// File: rtl/hdbn_pkg.sv
// Shared symbol encodings, polarity type and delay-line entry layout for the HDBn decoder.
package hdbn_pkg;

  // Line symbol encodings on indata
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  typedef enum logic {
    PolPos = 1'b0,
    PolNeg = 1'b1
  } pol_t;

  // One delay-line slot: decoded bit (1 only for a normal mark) and that mark's polarity
  typedef struct packed {
    logic mark;
    pol_t pol;
  } line_entry_t;

  // Polarity carried by a symbol; only meaningful for SYM_POS / SYM_NEG
  function automatic pol_t sym_pol(logic [1:0] sym);
    return (sym == SYM_NEG) ? PolNeg : PolPos;
  endfunction

endpackage

// File: rtl/hdbn_delay_line.sv
// Shift register of decoded line entries with an indexed clear applied after the shift,
// so a slot can be shifted and zeroed in the same cycle.
module hdbn_delay_line
  import hdbn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_en_i,
  input  line_entry_t       din_i,
  input  logic              clr_en_i,
  input  logic [IdxW-1:0]   clr_idx_i,
  output logic [DEPTH-1:0]  marks_o,
  output pol_t              b_pol_o
);

  line_entry_t [DEPTH-1:0] line_q, line_d;

  // Next line contents: optional shift, then optional clear of the post-shift slot
  always_comb begin
    line_d = line_q;
    if (shift_en_i) begin
      line_d[0] = din_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (clr_en_i && (clr_idx_i == IdxW'(i))) begin
        line_d[i].mark = 1'b0;
      end
    end
  end

  // Line storage with synchronous active-low reset to all zeros
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  // Index 0 is the newest entry; DEPTH-1 is the entry due for output next
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      marks_o[i] = line_q[i].mark;
    end
    b_pol_o = line_q[DEPTH-2].pol;
  end

endmodule

// File: rtl/hdbn_decoder.sv
// HDBn line decoder: removes V and B substitution marks from a ternary symbol stream.
// Optional violation detection (err pulse, saturating err_cnt) is built when the
// HDBN_ERR_EN macro is defined; decoded data is identical in both builds.
module hdbn_decoder
  import hdbn_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  indata,
  output logic        out_valid,
  output logic        outdata
`ifdef HDBN_ERR_EN
  ,
  output logic        err,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned Depth = N + 1;
  localparam int unsigned IdxW  = $clog2(Depth);

  logic        have_mark_q, have_mark_d;
  pol_t        last_pol_q, last_pol_d;
  logic        out_valid_q, out_valid_d;
  logic        outdata_q, outdata_d;

  logic [Depth-1:0] marks;
  pol_t             b_pol;
  line_entry_t      din;
  logic             is_mark, is_v, zeros_between, del_b;
  pol_t             cur_pol;

  hdbn_delay_line #(
    .DEPTH (Depth)
  ) u_line (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .shift_en_i (in_valid),
    .din_i      (din),
    .clr_en_i   (del_b),
    .clr_idx_i  (IdxW'(N)),
    .marks_o    (marks),
    .b_pol_o    (b_pol)
  );

  // Symbol classification and B deletion; the candidate B sits at slot N-1 before the
  // shift, i.e. the slot due for output next once this V is shifted in
  always_comb begin
    is_mark       = (indata == SYM_POS) || (indata == SYM_NEG);
    cur_pol       = sym_pol(indata);
    is_v          = is_mark && have_mark_q && (cur_pol == last_pol_q);
    zeros_between = ~|marks[N-2:0];
    del_b         = in_valid && is_v && marks[N-1] && (b_pol == cur_pol) && zeros_between;
    din.mark      = is_mark && !is_v;
    din.pol       = cur_pol;
  end

  // Polarity tracking and output next state
  always_comb begin
    have_mark_d = have_mark_q;
    last_pol_d  = last_pol_q;
    out_valid_d = in_valid;
    outdata_d   = outdata_q;
    if (in_valid) begin
      outdata_d = marks[N];
      if (is_mark) begin
        have_mark_d = 1'b1;
        last_pol_d  = cur_pol;
      end
    end
  end

  // Decoder state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_mark_q <= 1'b0;
      last_pol_q  <= PolPos;
      out_valid_q <= 1'b0;
      outdata_q   <= 1'b0;
    end else begin
      have_mark_q <= have_mark_d;
      last_pol_q  <= last_pol_d;
      out_valid_q <= out_valid_d;
      outdata_q   <= outdata_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outdata   = outdata_q;

`ifdef HDBN_ERR_EN
  logic [3:0]  zero_run_q, zero_run_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        viol;

  // Violation detection: illegal symbol, V without N-1 leading zeros, (N+1)-th zero in a row
  always_comb begin
    zero_run_d = zero_run_q;
    viol       = 1'b0;
    if (in_valid) begin
      viol = (indata == SYM_ILL) || (is_v && !zeros_between) ||
             ((indata == SYM_ZERO) && (zero_run_q == 4'(N)));
      if (indata == SYM_ZERO) begin
        zero_run_d = (zero_run_q == 4'(Depth)) ? zero_run_q : zero_run_q + 4'd1;
      end else begin
        zero_run_d = 4'd0;
      end
    end
    err_d     = viol;
    err_cnt_d = (viol && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // Error state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_run_q <= 4'd0;
      err_q      <= 1'b0;
      err_cnt_q  <= 16'd0;
    end else begin
      zero_run_q <= zero_run_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdbn_decoder.sv
// Directed bench for hdbn_decoder (N=3) with an expected-output scoreboard.
// Error-detection checks are compiled in when HDBN_ERR_EN is defined.
module tb_hdbn_decoder;
  import hdbn_pkg::*;

  localparam int unsigned N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  indata = SYM_ZERO;
  logic        out_valid;
  logic        outdata;
`ifdef HDBN_ERR_EN
  logic        err;
  logic [15:0] err_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  bit   q_dout[$];
  bit   q_err[$];
  logic acc_prev = 1'b0;

  hdbn_decoder #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .indata    (indata),
    .out_valid (out_valid),
    .outdata   (outdata)
`ifdef HDBN_ERR_EN
    ,
    .err       (err),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: out_valid must follow each accepted symbol by one cycle; data popped
  always @(negedge clk) begin
    bit exp_d;
    bit exp_e;
    n_vec++;
    assert (out_valid === acc_prev) else begin
      n_bad++;
      $error("FAIL out_valid: observed %b expected %b", out_valid, acc_prev);
    end
    acc_prev <= in_valid && rst_n;
    if (out_valid === 1'b1) begin
      n_vec++;
      if (q_dout.size() == 0) begin
        n_bad++;
        $error("FAIL dout_underflow: observed output %b expected none", outdata);
      end else begin
        exp_d = q_dout.pop_front();
        assert (outdata === exp_d) else begin
          n_bad++;
          $error("FAIL outdata: observed %b expected %b", outdata, exp_d);
        end
      end
`ifdef HDBN_ERR_EN
      n_vec++;
      if (q_err.size() == 0) begin
        n_bad++;
        $error("FAIL err_underflow: observed err %b expected none", err);
      end else begin
        exp_e = q_err.pop_front();
        assert (err === exp_e) else begin
          n_bad++;
          $error("FAIL err: observed %b expected %b", err, exp_e);
        end
      end
`endif
    end
`ifdef HDBN_ERR_EN
    else begin
      n_vec++;
      assert (err === 1'b0) else begin
        n_bad++;
        $error("FAIL err_idle: observed %b expected 0", err);
      end
    end
`endif
  end

  task automatic send(input logic [1:0] sym, input bit dec, input bit e);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    indata   = sym;
    q_dout.push_back(dec);
    q_err.push_back(e);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      indata   = SYM_ZERO;
    end
  endtask

  // One-cycle reset with in_valid held high; scoreboard restarts with N+1 primed zeros
  task automatic do_reset();
    idle(1);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    indata   = SYM_POS;
    q_dout.delete();
    q_err.delete();
    for (int i = 0; i < int'(N) + 1; i++) q_dout.push_back(1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    indata   = SYM_ZERO;
    n_vec++;
    assert (outdata === 1'b0 && out_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL reset_out: observed valid=%b data=%b expected 0/0", out_valid, outdata);
    end
`ifdef HDBN_ERR_EN
    n_vec++;
    assert (err === 1'b0 && err_cnt === 16'd0) else begin
      n_bad++;
      $error("FAIL reset_err: observed err=%b cnt=%h expected 0/0000", err, err_cnt);
    end
`endif
  endtask

`ifdef HDBN_ERR_EN
  task automatic check_cnt(input logic [15:0] exp_cnt);
    n_vec++;
    assert (err_cnt === exp_cnt) else begin
      n_bad++;
      $error("FAIL err_cnt: observed %h expected %h", err_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    do_reset();

    // Alternating marks: four primed zeros, then 1,1
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_POS, 1'b1, 1'b0);
    idle(3);

    // 000V substitution, flushed with zeros (fourth flush zero is a zero-run violation)
    do_reset();
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_POS, 1'b0, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(SYM_ZERO, 1'b0, i == 3);
    idle(3);

    // B00V substitution: B is deleted as it reaches the output slot
    do_reset();
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    send(SYM_POS, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_POS, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(SYM_ZERO, 1'b0, i == 3);
    idle(3);

    // Same B00V stream with in_valid gaps of 1..3 cycles
    do_reset();
    send(SYM_POS, 1'b1, 1'b0);
    idle(1);
    send(SYM_NEG, 1'b1, 1'b0);
    idle(2);
    send(SYM_POS, 1'b0, 1'b0);
    idle(3);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    idle(2);
    send(SYM_POS, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      send(SYM_ZERO, 1'b0, i == 3);
      idle(i % 3 + 1);
    end
    idle(2);

    // Mid-stream reset: outputs cleared, next mark decodes as a normal 1
    do_reset();
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    do_reset();
    send(SYM_POS, 1'b1, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_ZERO, 1'b0, 1'b0);
    send(SYM_NEG, 1'b1, 1'b0);
    idle(3);

`ifdef HDBN_ERR_EN
    // Illegal symbol then four zeros: two violations
    do_reset();
    send(SYM_ILL, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(SYM_ZERO, 1'b0, i == 3);
    idle(3);
    check_cnt(16'd2);
    // Drive the counter up to and past saturation
    for (int i = 0; i < 65532; i++) send(SYM_ILL, 1'b0, 1'b1);
    idle(3);
    check_cnt(16'hFFFE);
    send(SYM_ILL, 1'b0, 1'b1);
    idle(3);
    check_cnt(16'hFFFF);
    send(SYM_ILL, 1'b0, 1'b1);
    send(SYM_ILL, 1'b0, 1'b1);
    idle(3);
    check_cnt(16'hFFFF);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hdbn_decoder.md
HDBN_DECODER -- requirements
Module: hdbn_decoder

Interface
REQ-001 SHALL provide parameter N, default 3, meaning the zero-run length of the HDBn code, legal range 2..7 (HDB3 when N=3).
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit, reset; synchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 1 bit: indata carries a symbol this cycle.
REQ-005 SHALL provide port indata, input, 2 bits: 00 zero, 01 positive mark, 10 negative mark, 11 illegal.
REQ-006 SHALL provide port out_valid, output, 1 bit: outdata carries a decoded bit this cycle.
REQ-007 SHALL provide port outdata, output, 1 bit: decoded NRZ bit.
REQ-008 SHALL provide port err, output, 1 bit: one-cycle code-violation pulse (present only with HDBN_ERR_EN).
REQ-009 SHALL provide port err_cnt, output, 16 bits: saturating violation count (present only with HDBN_ERR_EN).

Function
REQ-010 SHALL accept one symbol per cycle with in_valid=1; cycles with in_valid=0 SHALL NOT advance any state.
REQ-011 SHALL hold decoded symbols in an (N+1)-stage delay line; each accepted symbol shifts the line by one.
REQ-012 SHALL drive out_valid one cycle after each accepted symbol, with outdata equal to the symbol decoded N+1 accepted symbols earlier.
REQ-013 SHALL output 0 for the first N+1 accepted symbols after reset (line primed with zeros).
REQ-014 SHALL decode a zero symbol as 0 and a normal mark as 1.
REQ-015 SHALL track last-mark polarity (POS/NEG) plus a have_mark flag; the first mark after reset SHALL always be a normal mark.
REQ-016 SHALL classify a mark as V when have_mark=1 and its polarity equals the last-mark polarity; V SHALL enter the line as 0.
REQ-017 SHALL, on a V, force to 0 the line entry N symbols before the V iff that entry was a mark of the same polarity as V and the N-1 entries between were zeros (B deletion); otherwise no entry is modified.
REQ-018 SHALL update last-mark polarity on every mark, V included.
REQ-019 SHALL treat indata=11 as a zero symbol for data purposes, without polarity update.
REQ-020 SHALL keep B deletion and V marking in the same cycle when a V is accepted while its B is at the line position due for output next, so no B ever leaves as 1.

Reset
REQ-021 SHALL, with rst_n=0 at a clock edge, clear delay line, have_mark, last polarity, out_valid, outdata, err and err_cnt to 0, regardless of in_valid.
REQ-022 SHALL discard all in-flight symbols on mid-stream reset; decoding restarts per REQ-013 and REQ-015.

Configuration
REQ-023 SHALL use macro HDBN_ERR_EN; when defined, err and err_cnt exist and are computed.
REQ-024 SHALL, with HDBN_ERR_EN, pulse err one cycle after accepting: indata=11; a V not preceded by N-1 zeros; or the (N+1)-th consecutive zero.
REQ-025 SHALL, with HDBN_ERR_EN, increment err_cnt on each err pulse and saturate at 16'hFFFF.
REQ-026 SHALL, without HDBN_ERR_EN, omit err, err_cnt and all detection logic; decoded data SHALL be identical in both builds.

Structure
REQ-027 SHALL place symbol encoding constants (SYM_ZERO, SYM_POS, SYM_NEG, SYM_ILL) and a polarity typedef in package hdbn_pkg.
REQ-028 SHALL implement the delay line as sub-module hdbn_delay_line (parameter DEPTH, shift-enable, indexed clear).

Verification (N=3)
REQ-029 SHALL cover: reset, symbols +1,-1,+1,-1,0,+1 -> first 4 outputs 0, then 1,1 on subsequent outputs; out_valid one cycle after each accept.
REQ-030 SHALL cover: +1,0,0,0,+1,-1 (000V) -> decoded bits 1,0,0,0,0,1.
REQ-031 SHALL cover: +1,-1,+1,0,0,+1 (B00V) -> decoded bits 1,1,0,0,0,0.
REQ-032 SHALL cover: in_valid gaps of 1-3 cycles within the REQ-031 stream -> same decoded bits, no out_valid during gaps.
REQ-033 SHALL cover with HDBN_ERR_EN: indata=11, then 0,0,0,0 -> two err pulses, err_cnt=2; err_cnt preset near 16'hFFFF stays 16'hFFFF.
REQ-034 SHALL cover: rst_n=0 for one cycle mid-REQ-031 stream -> all outputs 0 next cycle; next mark decoded as normal 1.
